// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA conditional-subtract sequencer.
package rsa_pkg;
  localparam int W_DEF  = 32;
  localparam int NW_DEF = 32;

  typedef enum logic [1:0] {IDLE, CMP, SUB, FIN} state_t;

  typedef logic [W_DEF-1:0] word_t;
endpackage

// File: rtl/cond_sub_ctrl_if.sv
// Operand-file / control bundle between the sequencer (master) and its environment.
interface cond_sub_ctrl_if
  import rsa_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF,
  parameter int AW = $clog2(NW)
);
  logic          start;
  logic          busy;
  logic          done;
  logic          ge;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  a_word;
  logic [W-1:0]  n_word;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  modport master (
    input  start, a_word, n_word,
    output busy, done, ge, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, a_word, n_word,
    input  busy, done, ge, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sub_w_borrow.sv
// W-bit subtract with borrow in/out: diff = a - b - bin, bout set when a < b + bin.
module sub_w_borrow #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_diff,
  output logic         o_bout
);
  logic [W:0] w_res;

  // Bit W of the (W+1)-bit result is the sign, i.e. the borrow out.
  assign w_res  = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
  assign o_diff = w_res[W-1:0];
  assign o_bout = w_res[W];
endmodule

// File: rtl/cond_sub_ctrl.sv
// Conditional subtract A := A - N when A >= N: MSW-first compare pass, then LSW-first
// borrow-chained subtract pass writing results back one word per cycle.
module cond_sub_ctrl
  import rsa_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF,
  parameter int AW = $clog2(NW)
) (
  input logic              clk,
  input logic              rst_n,
  cond_sub_ctrl_if.master  bus
);
  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_ge;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  logic          r_vld;
  logic [AW-1:0] r_dat_addr;
  logic          r_borrow;

  logic [W-1:0]  w_diff;
  logic          w_bout;
  logic          w_bin;
  logic          w_wr_en;

  // The compare reuses the subtractor: borrow-out means a < n, zero diff means equal.
  assign w_bin = (r_state == SUB) & r_borrow;

  sub_w_borrow #(.W(W)) u_sub (
    .i_a    (bus.a_word),
    .i_b    (bus.n_word),
    .i_bin  (w_bin),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  // Writes land in the same cycle the read data returns, so the write strobe is
  // the registered valid qualified by state rather than a separate register.
  assign w_wr_en     = (r_state == SUB) & r_vld;
  assign bus.wr_en   = w_wr_en;
  assign bus.wr_data = w_wr_en ? w_diff : '0;
  assign bus.wr_addr = r_dat_addr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ge      = r_ge;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ge       <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_vld      <= 1'b0;
      r_dat_addr <= '0;
      r_borrow   <= 1'b0;
    end else begin
      r_vld      <= r_rd_en;
      r_dat_addr <= r_rd_addr;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= CMP;
            r_busy    <= 1'b1;
            r_ge      <= 1'b0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= AW'(NW-1);
            r_borrow  <= 1'b0;
          end
        end
        CMP: begin
          if (r_rd_en) begin
            if (r_rd_addr == '0) r_rd_en   <= 1'b0;
            else                 r_rd_addr <= r_rd_addr - AW'(1);
          end
          // A decision overrides the read just issued; its data is dropped via r_vld.
          if (r_vld) begin
            if (w_bout) begin
              r_ge    <= 1'b0;
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_rd_en <= 1'b0;
              r_vld   <= 1'b0;
            end else if (w_diff != '0 || r_dat_addr == '0) begin
              r_ge      <= 1'b1;
              r_state   <= SUB;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
              r_vld     <= 1'b0;
              r_borrow  <= 1'b0;
            end
          end
        end
        SUB: begin
          if (r_rd_en) begin
            if (r_rd_addr == AW'(NW-1)) r_rd_en   <= 1'b0;
            else                        r_rd_addr <= r_rd_addr + AW'(1);
          end
          if (r_vld) begin
            r_borrow <= w_bout;
            if (r_dat_addr == AW'(NW-1)) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
